// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: assembles one 16-bit MSB-first SPI frame per nCS-low window
// in the system clock domain, validates it and issues a single-cycle register
// write strobe. It also keeps saturating good/bad frame counters for bring-up.
module spi_frame_ctrl #(
   parameter logic [6:0] MAX_ADDR = 7'h04,
   parameter int         CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk_s,
   input  logic             ncs_s,
   input  logic             copi_s,
   input  logic             stat_clr,
   output logic             wr_en,
   output logic [6:0]       wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy,
   output logic [CNT_W-1:0] ok_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {ARM, IDLE, SHIFT, COMMIT, DRAIN} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [15:0]      sh_q, sh_d;
   logic             sclk_q;
   logic             wr_en_q, wr_en_d;
   logic [6:0]       wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [CNT_W-1:0] ok_q, ok_d, err_q, err_d;
   logic             ok_inc, err_inc;
   logic             rise;
   logic             frame_wr, addr_ok;

   assign rise     = sclk_s & ~sclk_q;
   assign frame_wr = sh_q[15];
   assign addr_ok  = (sh_q[14:8] <= MAX_ADDR);

   // Next-state, shifting and frame classification.
   // The strobe is registered on the SHIFT->COMMIT edge so it is high
   // exactly during the COMMIT cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ok_inc    = 1'b0;
      err_inc   = 1'b0;
      case (state_q)
         ARM: begin
            // Wait for a clean nCS-high so a frame already in flight is skipped
            if (ncs_s) state_d = IDLE;
         end
         IDLE: begin
            if (!ncs_s) begin
               state_d = SHIFT;
               cnt_d   = 5'd0;
               if (rise) begin
                  sh_d  = {sh_q[14:0], copi_s};
                  cnt_d = 5'd1;
               end
            end
         end
         SHIFT: begin
            // nCS release wins over a coincident SCLK rise
            if (ncs_s) begin
               if (cnt_q == 5'd16) begin
                  state_d = COMMIT;
                  if (frame_wr && addr_ok) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = sh_q[14:8];
                     wr_data_d = sh_q[7:0];
                  end
               end else begin
                  err_inc = 1'b1;
                  state_d = IDLE;
               end
            end else if (rise) begin
               if (cnt_q == 5'd16) begin
                  state_d = DRAIN;
               end else begin
                  sh_d  = {sh_q[14:0], copi_s};
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         COMMIT: begin
            if (frame_wr && !addr_ok) err_inc = 1'b1;
            else                      ok_inc  = 1'b1;
            state_d = IDLE;
         end
         DRAIN: begin
            if (ncs_s) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = ARM;
      endcase
   end

   // Saturating counters; a clear beats a coincident increment
   always_comb begin
      ok_d  = ok_q;
      err_d = err_q;
      if (stat_clr) begin
         ok_d  = '0;
         err_d = '0;
      end else begin
         if (ok_inc  && ok_q  != CNT_MAX) ok_d  = ok_q  + CNT_ONE;
         if (err_inc && err_q != CNT_MAX) err_d = err_q + CNT_ONE;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ARM;
         cnt_q     <= 5'd0;
         sh_q      <= 16'd0;
         sclk_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 7'd0;
         wr_data_q <= 8'd0;
         ok_q      <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         sclk_q    <= sclk_s;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = (state_q == SHIFT) || (state_q == COMMIT) || (state_q == DRAIN);
   assign ok_cnt  = ok_q;
   assign err_cnt = err_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: a directed vector table, hand sequences for
// DRAIN / mid-frame reset / saturation + clear, and randomized frames
// scored against a frame-level reference model.
module tb_spi_frame_ctrl;

   localparam int CNT_W = 8;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n, sclk_s, ncs_s, copi_s, stat_clr;
   logic             wr_en;
   logic [6:0]       wr_addr;
   logic [7:0]       wr_data;
   logic             busy;
   logic [CNT_W-1:0] ok_cnt, err_cnt;

   spi_frame_ctrl #(.MAX_ADDR(7'h04), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .sclk_s(sclk_s), .ncs_s(ncs_s), .copi_s(copi_s),
      .stat_clr(stat_clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Strobe monitor: counts pulses, captures payload, flags back-to-back strobes
   int         tot_pulses = 0;
   logic [6:0] cap_addr = '0;
   logic [7:0] cap_data = '0;
   logic       wr_prev = 1'b0;
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         tot_pulses++;
         cap_addr = wr_addr;
         cap_data = wr_data;
         chk("wr_en_not_consecutive", int'(wr_prev), 0);
      end
      wr_prev = (wr_en === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shift n bits MSB first, 2 clk low + 2 clk high per SCLK period
   task automatic shift_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         copi_s = bits[i];
         sclk_s = 1'b0; tick(); tick();
         sclk_s = 1'b1; tick(); tick();
      end
   endtask

   // Release nCS; optionally pulse stat_clr during the COMMIT cycle
   task automatic end_frame(input bit clr);
      sclk_s = 1'b0; tick();
      ncs_s  = 1'b1; tick();
      if (clr) stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      tick(); tick();
   endtask

   // Reference model: frame-level bookkeeping from the frame rules
   int         ok_m = 0, err_m = 0;
   logic [6:0] addr_m = '0;
   logic [7:0] data_m = '0;

   function automatic int sat_inc(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   task automatic run_frame(input string tag, input logic [31:0] bits, input int n, input bit clr);
      int         p0;
      bit         exp_wr;
      logic [15:0] f;
      f      = bits[15:0];
      exp_wr = 1'b0;
      if (n == 16) begin
         if (f[15] && f[14:8] <= 7'h04) begin
            exp_wr = 1'b1;
            addr_m = f[14:8];
            data_m = f[7:0];
            ok_m   = sat_inc(ok_m);
         end else if (f[15]) begin
            err_m = sat_inc(err_m);
         end else begin
            ok_m = sat_inc(ok_m);
         end
      end else begin
         err_m = sat_inc(err_m);
      end
      if (clr) begin ok_m = 0; err_m = 0; end
      p0 = tot_pulses;
      ncs_s = 1'b0; tick();
      shift_bits(bits, n);
      end_frame(clr);
      chk({tag, "_pulses"}, tot_pulses - p0, int'(exp_wr));
      if (exp_wr) begin
         chk({tag, "_cap_addr"}, int'(cap_addr), int'(addr_m));
         chk({tag, "_cap_data"}, int'(cap_data), int'(data_m));
      end
      chk({tag, "_wr_addr_hold"}, int'(wr_addr), int'(addr_m));
      chk({tag, "_wr_data_hold"}, int'(wr_data), int'(data_m));
      chk({tag, "_ok_cnt"}, int'(ok_cnt), ok_m);
      chk({tag, "_err_cnt"}, int'(err_cnt), err_m);
      chk({tag, "_busy_idle"}, int'(busy), 0);
   endtask

   typedef struct {
      logic [31:0] bits;
      int          n;
      int          exp_pulses;
      int          exp_addr;
      int          exp_data;
      int          exp_ok;
      int          exp_err;
   } vec_t;

   vec_t vec[8];

   initial begin
      vec[0] = '{32'h8455,  16, 1, 'h04, 'h55, 1, 0};
      vec[1] = '{32'h0133,  16, 0, 'h04, 'h55, 2, 0};
      vec[2] = '{32'h85AA,  16, 0, 'h04, 'h55, 2, 1};
      vec[3] = '{32'h0ABC,  12, 0, 'h04, 'h55, 2, 2};
      vec[4] = '{32'h80FF,  16, 1, 'h00, 'hFF, 3, 2};
      vec[5] = '{32'h8300,  16, 1, 'h03, 'h00, 4, 2};
      vec[6] = '{32'hFFFF,  16, 0, 'h03, 'h00, 4, 3};
      vec[7] = '{32'h1FFFF, 17, 0, 'h03, 'h00, 4, 4};

      rst_n = 1'b0; ncs_s = 1'b1; sclk_s = 1'b0; copi_s = 1'b0; stat_clr = 1'b0;
      tick(); tick(); tick();
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ok_cnt", int'(ok_cnt), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      rst_n = 1'b1; tick(); tick();

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         int p0;
         p0 = tot_pulses;
         ncs_s = 1'b0; tick();
         shift_bits(vec[i].bits, vec[i].n);
         end_frame(1'b0);
         chk($sformatf("vec%0d_pulses", i), tot_pulses - p0, vec[i].exp_pulses);
         chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), vec[i].exp_addr);
         chk($sformatf("vec%0d_wr_data", i), int'(wr_data), vec[i].exp_data);
         chk($sformatf("vec%0d_ok_cnt", i), int'(ok_cnt), vec[i].exp_ok);
         chk($sformatf("vec%0d_err_cnt", i), int'(err_cnt), vec[i].exp_err);
      end
      ok_m = 4; err_m = 4; addr_m = 7'h03; data_m = 8'h00;

      // 17-bit frame: error only counted once nCS rises
      begin
         int p0;
         p0 = tot_pulses;
         ncs_s = 1'b0; tick();
         shift_bits(32'h12345, 17);
         tick(); tick();
         chk("drain_busy", int'(busy), 1);
         chk("drain_err_held", int'(err_cnt), err_m);
         end_frame(1'b0);
         err_m = sat_inc(err_m);
         chk("drain_err_cnt", int'(err_cnt), err_m);
         chk("drain_pulses", tot_pulses - p0, 0);
      end

      // Reset after 8 bits with nCS low; rest of frame must be ignored
      begin
         int p0;
         p0 = tot_pulses;
         ncs_s = 1'b0; tick();
         shift_bits(32'h84, 8);
         rst_n = 1'b0; tick();
         rst_n = 1'b1; tick();
         chk("midrst_busy", int'(busy), 0);
         chk("midrst_ok_cnt", int'(ok_cnt), 0);
         chk("midrst_err_cnt", int'(err_cnt), 0);
         shift_bits(32'h77, 8);
         chk("midrst_busy_tail", int'(busy), 0);
         end_frame(1'b0);
         chk("midrst_pulses", tot_pulses - p0, 0);
         chk("midrst_ok_after", int'(ok_cnt), 0);
         chk("midrst_err_after", int'(err_cnt), 0);
         ok_m = 0; err_m = 0; addr_m = '0; data_m = '0;
         run_frame("post_rst", 32'h8011, 16, 1'b0);
      end

      // Randomized frames against the reference model
      for (int k = 0; k < 40; k++) begin
         int          r, n;
         logic [31:0] b;
         r = $urandom_range(0, 9);
         b = $urandom;
         if (r < 6) begin
            n = 16;
            b[14:8] = 7'($urandom_range(0, 6));
         end else if (r == 6) begin
            n = $urandom_range(1, 15);
         end else if (r == 7) begin
            n = $urandom_range(17, 19);
         end else begin
            n = 16;
         end
         run_frame($sformatf("rnd%0d", k), b, n, 1'b0);
      end

      // Back-to-back valid frames drive ok_cnt into saturation
      for (int k = 0; k < 300; k++) begin
         logic [31:0] b;
         b = 32'h8000 | ((k % 5) << 8) | (k & 8'hFF);
         run_frame($sformatf("sat%0d", k), b, 16, 1'b0);
      end
      chk("sat_ok_cnt", int'(ok_cnt), SAT);

      // Clear coinciding with a COMMIT beats the increment
      run_frame("clr_commit", 32'h8122, 16, 1'b1);
      chk("clr_ok_zero", int'(ok_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
